ntt_bram_host: RTL

- PL-side host for the NTT BRAM. Owns the BRAM port opposite the NTT core's port and handles the NTT core's reset/done handshake.
- Load phase: accepts a stream of 64-bit coefficients and writes them into BRAM.
- Run phase: releases the NTT core from reset and waits for its done pulse.
- Drain phase: reads the transformed words back out of BRAM as a stream.
- Lets the NTT run without the Zynq PS in the loop.

---
 rtl/ntt_bram_host.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ntt_bram_host.sv
// PL-side host for the NTT BRAM: streams coefficients in, runs the NTT core
// through its reset/done handshake, then streams the transformed words out.
module ntt_bram_host #(
   parameter int N_WORDS = 1024,
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 64,
   parameter int RD_LAT  = 1,
   parameter int TIMEOUT = 65535
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic [ADDR_W-1:0] bram_addr,
   output logic              bram_clk,
   output logic [DATA_W-1:0] bram_din,
   input  logic [DATA_W-1:0] bram_dout,
   output logic              bram_en,
   output logic              bram_rst,
   output logic              bram_we,
   output logic              ntt_rst,
   input  logic              ntt_done,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int                T_W    = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(N_WORDS - 1);
   localparam logic [T_W-1:0]    T_LAST = T_W'(TIMEOUT - 1);
   localparam logic [1:0]        L_LAST = 2'(RD_LAT - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_RUN, S_ARM, S_WAIT, S_RD_REQ, S_RD_WAIT, S_OUT, S_DONE
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] cnt;   // word index for both load and drain
   logic [T_W-1:0]    tcnt;  // cycles spent waiting for the NTT core
   logic [1:0]        lcnt;  // BRAM read latency counter

   // The BRAM port shares the host clock and reset.
   assign bram_clk = clk;
   assign bram_rst = rst;

   // Control FSM. Outputs that belong to a state are set on the transition
   // into it, so they are registered and valid for the whole state.
   // NOTE: every assignment here is non-blocking so all registers update
   // together from the values sampled at the same clock edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         tcnt      <= '0;
         lcnt      <= '0;
         in_ready  <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         bram_addr <= '0;
         bram_din  <= '0;
         bram_en   <= 1'b0;
         bram_we   <= 1'b0;
         ntt_rst   <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  done     <= 1'b0;
                  error    <= 1'b0;
                  cnt      <= '0;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
                  state    <= S_LOAD;
               end
            end
            S_LOAD: begin
               bram_en <= 1'b0;
               bram_we <= 1'b0;
               if (in_valid && in_ready) begin
                  bram_en   <= 1'b1;
                  bram_we   <= 1'b1;
                  bram_addr <= cnt;
                  bram_din  <= in_data;
                  if (cnt == LAST) begin
                     in_ready <= 1'b0;
                     state    <= S_RUN;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            S_RUN: begin
               bram_en <= 1'b0;
               bram_we <= 1'b0;
               ntt_rst <= 1'b0;
               tcnt    <= '0;
               state   <= S_ARM;
            end
            S_ARM: begin
               // A done still high from a previous run must drop first.
               if (tcnt == T_LAST) begin
                  error   <= 1'b1;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  ntt_rst <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  tcnt <= tcnt + 1'b1;
                  if (!ntt_done) state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (ntt_done) begin
                  ntt_rst   <= 1'b1;
                  cnt       <= '0;
                  bram_en   <= 1'b1;
                  bram_addr <= '0;
                  state     <= S_RD_REQ;
               end else if (tcnt == T_LAST) begin
                  error   <= 1'b1;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  ntt_rst <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            S_RD_REQ: begin
               bram_en <= 1'b0;
               lcnt    <= '0;
               state   <= S_RD_WAIT;
            end
            S_RD_WAIT: begin
               if (lcnt == L_LAST) begin
                  out_data  <= bram_dout;
                  out_valid <= 1'b1;
                  out_last  <= (cnt == LAST);
                  state     <= S_OUT;
               end else begin
                  lcnt <= lcnt + 1'b1;
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  if (cnt == LAST) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_DONE;
                  end else begin
                     cnt       <= cnt + 1'b1;
                     bram_en   <= 1'b1;
                     bram_addr <= cnt + 1'b1;
                     state     <= S_RD_REQ;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
